dds_csr_mc: RTL

Parametrised multi-channel Avalon-MM control/status register block for the DDS sine generators.
- Holds per-channel frequency control words (FCW) in shadow/active pairs with atomic commit.
- Holds per-channel run and interrupt-enable bits.
- Captures the latest sine sample per channel on each sample tick.
- Raises a level interrupt every IRQ_PERIOD sample ticks, with write-1-to-clear pending and overrun status.
- Sits between the system interconnect and NUM_CH phase-accumulator/LUT datapaths.

---
 rtl/dds_csr_pkg.sv | 28 ++
 rtl/dds_csr_chan.sv | 87 ++++++++
 rtl/dds_csr_mc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dds_csr_pkg.sv
// dds_csr_pkg: shared register map constants and address helpers for the
// multi-channel DDS control/status register block.
//   - ADDR_*  : fixed word addresses of the global registers
//   - *_LSB   : bit-field offsets inside CTRL, STATUS and COMMIT
//   - ch_fcw_addr / ch_sample_addr : per-channel word addresses
package dds_csr_pkg;

  localparam int ADDR_CTRL    = 32'sd0;
  localparam int ADDR_STATUS  = 32'sd1;
  localparam int ADDR_PERIOD  = 32'sd2;
  localparam int ADDR_COMMIT  = 32'sd3;
  localparam int ADDR_CH_BASE = 32'sd4;

  localparam int RUN_LSB   = 32'sd0;
  localparam int IRQEN_LSB = 32'sd16;
  localparam int OVR_LSB   = 32'sd16;
  localparam int CLR_LSB   = 32'sd16;

  // Each channel owns two consecutive words: shadow FCW, then sample.
  function automatic int ch_fcw_addr(input int ch);
    return ADDR_CH_BASE + 32'sd2 * ch;
  endfunction

  function automatic int ch_sample_addr(input int ch);
    return ADDR_CH_BASE + 32'sd2 * ch + 32'sd1;
  endfunction

endpackage

// File: rtl/dds_csr_chan.sv
// dds_csr_chan: per-channel register slice of the DDS CSR block.
// Ports:
//   Clk, ResetN          clock, asynchronous active-low reset
//   fcw_wr, fcw_wdata    shadow FCW write strobe and data
//   commit               copy shadow FCW into active FCW
//   clr_req              request a one-cycle phase clear pulse
//   capture, sample_in   sample capture strobe and current sine sample
//   evt_set              interrupt event for this (running) channel
//   pend_w1c, ovr_w1c    write-1-to-clear strobes for pending/overrun
//   fcw_sh, fcw_act      shadow and active FCW
//   sample               last captured sample
//   pending, overrun     status bits
//   phase_clr            registered phase-accumulator clear pulse
module dds_csr_chan #(
  parameter int FCW_W  = 16,
  parameter int DATA_W = 10
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              fcw_wr,
  input  logic [FCW_W-1:0]  fcw_wdata,
  input  logic              commit,
  input  logic              clr_req,
  input  logic              capture,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              evt_set,
  input  logic              pend_w1c,
  input  logic              ovr_w1c,
  output logic [FCW_W-1:0]  fcw_sh,
  output logic [FCW_W-1:0]  fcw_act,
  output logic [DATA_W-1:0] sample,
  output logic              pending,
  output logic              overrun,
  output logic              phase_clr
);

  logic [FCW_W-1:0]  fcw_sh_r;
  logic [FCW_W-1:0]  fcw_act_r;
  logic [DATA_W-1:0] sample_r;
  logic              pending_r;
  logic              overrun_r;
  logic              phase_clr_r;

  // Channel state: shadow/active FCW, sample, status bits and clear pulse.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      fcw_sh_r    <= {FCW_W{1'b0}};
      fcw_act_r   <= {FCW_W{1'b0}};
      sample_r    <= {DATA_W{1'b0}};
      pending_r   <= 1'b0;
      overrun_r   <= 1'b0;
      phase_clr_r <= 1'b0;
    end else begin
      if (fcw_wr) begin
        fcw_sh_r <= fcw_wdata;
      end
      // A commit in the same cycle as a shadow write takes the old shadow.
      if (commit) begin
        fcw_act_r <= fcw_sh_r;
      end
      phase_clr_r <= clr_req;
      if (capture) begin
        sample_r <= sample_in;
      end
      // Hardware set beats a simultaneous write-1-to-clear.
      if (evt_set) begin
        pending_r <= 1'b1;
      end else if (pend_w1c) begin
        pending_r <= 1'b0;
      end
      // Overrun looks at pending before this cycle's clear is applied.
      if (evt_set && pending_r) begin
        overrun_r <= 1'b1;
      end else if (ovr_w1c) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign fcw_sh    = fcw_sh_r;
  assign fcw_act   = fcw_act_r;
  assign sample    = sample_r;
  assign pending   = pending_r;
  assign overrun   = overrun_r;
  assign phase_clr = phase_clr_r;

endmodule

// File: rtl/dds_csr_mc.sv
// dds_csr_mc: Avalon-MM control/status register block for NUM_CH DDS
// sine generators.
// Ports:
//   Clk, ResetN                       clock, asynchronous active-low reset
//   ChipSelect, Write, Read, Address  Avalon-MM slave controls (word address)
//   WriteData / ReadData              32-bit data; ReadData registered, 1-cycle latency
//   sample_tick                       one-cycle pulse per output sample
//   data_sin                          current samples, channel 0 in LSBs
//   run                               per-channel run enable
//   fcw                               active FCWs, channel 0 in LSBs
//   phase_clr                         one-cycle phase-accumulator clear pulses
//   irq                               level interrupt
module dds_csr_mc
  import dds_csr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int FCW_W  = 16,
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic                     ChipSelect,
  input  logic                     Write,
  input  logic                     Read,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [31:0]              WriteData,
  output logic [31:0]              ReadData,
  input  logic                     sample_tick,
  input  logic [NUM_CH*DATA_W-1:0] data_sin,
  output logic [NUM_CH-1:0]        run,
  output logic [NUM_CH*FCW_W-1:0]  fcw,
  output logic [NUM_CH-1:0]        phase_clr,
  output logic                     irq
);

  logic              wr_s;
  logic              rd_s;
  logic              ctrl_wr_s;
  logic              status_wr_s;
  logic              period_wr_s;
  logic              commit_wr_s;
  logic              evt_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  logic [NUM_CH-1:0] run_r;
  logic [NUM_CH-1:0] irq_en_r;
  logic [15:0]       period_r;
  logic [15:0]       cnt_r;
  logic [31:0]       rdata_r;
  logic              irq_r;

  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] overrun_s;
  logic [31:0]       fcw_rd_s    [NUM_CH];
  logic [31:0]       sample_rd_s [NUM_CH];

  assign wr_s        = ChipSelect & Write;
  assign rd_s        = ChipSelect & Read;
  assign ctrl_wr_s   = wr_s && (Address == ADDR_W'(ADDR_CTRL));
  assign status_wr_s = wr_s && (Address == ADDR_W'(ADDR_STATUS));
  assign period_wr_s = wr_s && (Address == ADDR_W'(ADDR_PERIOD));
  assign commit_wr_s = wr_s && (Address == ADDR_W'(ADDR_COMMIT));
  // Only some WriteData bits map to register fields.
  assign unused_s    = ^WriteData;

  // Event fires on the tick that completes a period; a PERIOD write wins.
  always_comb begin
    evt_s = 1'b0;
    if (sample_tick && (period_r != 16'd0) && (cnt_r == period_r - 16'd1) && !period_wr_s) begin
      evt_s = 1'b1;
    end else begin
      evt_s = 1'b0;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [FCW_W-1:0]  fcw_sh_s;
    logic [DATA_W-1:0] sample_s;

    dds_csr_chan #(
      .FCW_W  (FCW_W),
      .DATA_W (DATA_W)
    ) u_chan (
      .Clk       (Clk),
      .ResetN    (ResetN),
      .fcw_wr    (wr_s && (Address == ADDR_W'(ch_fcw_addr(ch)))),
      .fcw_wdata (WriteData[FCW_W-1:0]),
      .commit    (commit_wr_s && WriteData[ch]),
      .clr_req   (commit_wr_s && WriteData[CLR_LSB+ch]),
      .capture   (sample_tick && run_r[ch]),
      .sample_in (data_sin[ch*DATA_W +: DATA_W]),
      .evt_set   (evt_s && run_r[ch]),
      .pend_w1c  (status_wr_s && WriteData[ch]),
      .ovr_w1c   (status_wr_s && WriteData[OVR_LSB+ch]),
      .fcw_sh    (fcw_sh_s),
      .fcw_act   (fcw[ch*FCW_W +: FCW_W]),
      .sample    (sample_s),
      .pending   (pending_s[ch]),
      .overrun   (overrun_s[ch]),
      .phase_clr (phase_clr[ch])
    );

    assign fcw_rd_s[ch]    = 32'(fcw_sh_s);
    assign sample_rd_s[ch] = 32'(sample_s);
  end

  // CTRL and PERIOD registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      run_r    <= {NUM_CH{1'b0}};
      irq_en_r <= {NUM_CH{1'b0}};
      period_r <= 16'd0;
    end else begin
      if (ctrl_wr_s) begin
        run_r    <= WriteData[RUN_LSB +: NUM_CH];
        irq_en_r <= WriteData[IRQEN_LSB +: NUM_CH];
      end
      if (period_wr_s) begin
        period_r <= WriteData[15:0];
      end
    end
  end

  // Tick counter: cleared by a PERIOD write, parked at 0 while PERIOD is 0.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      cnt_r <= 16'd0;
    end else if (period_wr_s || (period_r == 16'd0)) begin
      cnt_r <= 16'd0;
    end else if (sample_tick) begin
      if (cnt_r == period_r - 16'd1) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  // Read mux over current (pre-write) register values.
  always_comb begin
    rdata_s = 32'd0;
    case (Address)
      ADDR_W'(ADDR_CTRL): begin
        rdata_s[RUN_LSB +: NUM_CH]   = run_r;
        rdata_s[IRQEN_LSB +: NUM_CH] = irq_en_r;
      end
      ADDR_W'(ADDR_STATUS): begin
        rdata_s[NUM_CH-1:0]        = pending_s;
        rdata_s[OVR_LSB +: NUM_CH] = overrun_s;
      end
      ADDR_W'(ADDR_PERIOD): begin
        rdata_s[15:0] = period_r;
      end
      default: begin
        // COMMIT and unmapped words fall through with 0.
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (Address == ADDR_W'(ch_fcw_addr(ch))) begin
            rdata_s = fcw_rd_s[ch];
          end else if (Address == ADDR_W'(ch_sample_addr(ch))) begin
            rdata_s = sample_rd_s[ch];
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    endcase
  end

  // Registered read data and interrupt level.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rdata_r <= 32'd0;
      irq_r   <= 1'b0;
    end else begin
      if (rd_s) begin
        rdata_r <= rdata_s;
      end
      irq_r <= |(pending_s & irq_en_r);
    end
  end

  assign ReadData = rdata_r;
  assign run      = run_r;
  assign irq      = irq_r;

endmodule
